// File: rtl/sram_ms_pkg.sv
// sram_ms_pkg: rail levels, read FSM states and logic/real conversion helpers
package sram_ms_pkg;
  localparam real VDD = 1.5;
  localparam real VSS = 0.0;
  localparam real VTH = 0.8;
  typedef enum logic [1:0] {IDLE, PRE, ACC, RESP} rd_state_e;
  function automatic real to_real(logic b);
    return b ? VDD : VSS;
  endfunction
  function automatic logic to_logic(real v);
    return v >= VTH;
  endfunction
endpackage

// File: rtl/sram_read_ctrl_if.sv
// sram_read_ctrl_if: read request and response handshake bundle
interface sram_read_ctrl_if #(parameter int ROWS = 4, parameter int COLS = 8);
  localparam int AW = ROWS > 1 ? $clog2(ROWS) : 1;
  logic req_valid;
  logic req_ready;
  logic [AW-1:0] req_addr;
  logic [COLS-1:0] rd_data;
  logic rd_valid;
  logic rd_ready;
  logic rd_err;
  modport master(output req_valid, req_addr, rd_ready, input req_ready, rd_data, rd_valid, rd_err);
  modport slave(input req_valid, req_addr, rd_ready, output req_ready, rd_data, rd_valid, rd_err);
endinterface

// File: rtl/rd_phase_timer.sv
// rd_phase_timer: loadable down-counter timing the precharge and word-line phases
module rd_phase_timer #(parameter int W = 2) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= load_val;
    else if (dec && cnt != '0) cnt <= cnt - W'(1);
  end
  assign done = cnt == '0;
endmodule

// File: rtl/sram_read_ctrl.sv
// sram_read_ctrl: precharge / word-line / sample sequencer in front of the sense amps
module sram_read_ctrl
  import sram_ms_pkg::*;
#(
  parameter int ROWS    = 4,
  parameter int COLS    = 8,
  parameter int PRE_CYC = 2,
  parameter int WL_CYC  = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  sram_read_ctrl_if.slave  bus,
  output real              pchg,
  output real              row_rd [ROWS],
  input  real              preout [1][COLS]
);
  localparam int AW = ROWS > 1 ? $clog2(ROWS) : 1;
  localparam int TW = $clog2(PRE_CYC > WL_CYC ? PRE_CYC : WL_CYC) + 1;
  rd_state_e state, state_d;
  logic [AW-1:0] addr, addr_d;
  logic accept, bad, done, load;
  logic [TW-1:0] load_val;
  logic pchg_d, valid_d, ready_d;
  logic [ROWS-1:0] row_d;
  logic [COLS-1:0] word;
  assign accept   = state == IDLE && bus.req_valid;
  assign bad      = int'(bus.req_addr) >= ROWS;
  assign load     = (accept && !bad) || (state == PRE && done);
  assign load_val = state == PRE ? TW'(WL_CYC - 1) : TW'(PRE_CYC - 1);
  rd_phase_timer #(.W(TW)) timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (load),
    .load_val (load_val),
    .dec      (state == PRE || state == ACC),
    .done     (done)
  );
  always_comb begin
    addr_d  = accept ? bus.req_addr : addr;
    state_d = state == IDLE ? (accept ? (bad ? RESP : PRE) : IDLE) :
              state == PRE  ? (done ? ACC : PRE) :
              state == ACC  ? (done ? RESP : ACC) :
                              (bus.rd_ready ? IDLE : RESP);
  end
  // outputs are registered from the next state so they line up with the state register
  always_comb begin
    pchg_d  = state_d == PRE;
    valid_d = state_d == RESP;
    ready_d = state_d == IDLE;
    for (int r = 0; r < ROWS; r++) row_d[r] = state_d == ACC && int'(addr_d) == r;
    for (int c = 0; c < COLS; c++) word[c] = to_logic(preout[0][c]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      addr          <= '0;
      pchg          <= VSS;
      for (int r = 0; r < ROWS; r++) row_rd[r] <= VSS;
      bus.rd_data   <= '0;
      bus.rd_err    <= 1'b0;
      bus.rd_valid  <= 1'b0;
      bus.req_ready <= 1'b1;
    end else begin
      state         <= state_d;
      addr          <= addr_d;
      pchg          <= to_real(pchg_d);
      for (int r = 0; r < ROWS; r++) row_rd[r] <= to_real(row_d[r]);
      bus.rd_valid  <= valid_d;
      bus.req_ready <= ready_d;
      if (accept && bad) begin
        bus.rd_data <= '0;
        bus.rd_err  <= 1'b1;
      end else if (state == ACC && done) begin
        bus.rd_data <= word;
        bus.rd_err  <= 1'b0;
      end
    end
  end
endmodule
